// File: rtl/packet_disassembler.sv
// HDMI data-island packet receiver: rebuilds the header and four subpackets from the
// 9-bit per-pixel stream, rechecks the BCH parity of every block and strobes each packet out.
module packet_disassembler #(
  parameter bit DROP_BAD = 1'b0
) (
  input  logic                  clk_pixel,
  input  logic                  reset,
  input  logic                  data_island_period,
  input  logic [8:0]            packet_data,
  output logic [23:0]           header,
  output logic [3:0][55:0]      sub,
  output logic                  header_ecc_ok,
  output logic [3:0]            sub_ecc_ok,
  output logic                  packet_valid,
  output logic                  packet_error,
  output logic [4:0]            counter
);

  localparam int unsigned HDR_W     = 24;
  localparam int unsigned SUB_W     = 56;
  localparam int unsigned ECC_W     = 8;
  localparam int unsigned NUM_SUB   = 4;
  localparam int unsigned CNT_W     = 5;
  localparam int unsigned HDR_BEATS = 24;
  localparam int unsigned SUB_BEATS = 28;
  localparam int unsigned LAST_BEAT = 31;
  localparam logic [ECC_W-1:0] BCH_POLY = 8'h83;

  // One bit of the LSB-first BCH(64,56)/(32,24) parity recurrence.
  function automatic logic [ECC_W-1:0] ecc_step(input logic [ECC_W-1:0] ecc, input logic b);
    return (ecc >> 1) ^ (((ecc[0] ^ b) == 1'b1) ? BCH_POLY : ECC_W'(0));
  endfunction

  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [HDR_W-1:0]              hdr_cap_q, hdr_cap_d;
  logic [ECC_W-1:0]              hdr_par_q, hdr_par_d;
  logic [ECC_W-1:0]              hdr_ecc_q, hdr_ecc_d;
  logic [NUM_SUB-1:0][SUB_W-1:0] sub_cap_q, sub_cap_d;
  logic [NUM_SUB-1:0][ECC_W-1:0] sub_par_q, sub_par_d;
  logic [NUM_SUB-1:0][ECC_W-1:0] sub_ecc_q, sub_ecc_d;

  logic [HDR_W-1:0]              header_q, header_d;
  logic [NUM_SUB-1:0][SUB_W-1:0] sub_q, sub_d;
  logic                          hdr_ok_q, hdr_ok_d;
  logic [NUM_SUB-1:0]            sub_ok_q, sub_ok_d;
  logic                          valid_q, valid_d;
  logic                          error_q, error_d;

  logic                          last_beat_c;
  logic                          hdr_ok_c;
  logic [NUM_SUB-1:0]            sub_ok_c;
  logic                          pkt_err_c;

  assign last_beat_c = data_island_period && (cnt_q == CNT_W'(LAST_BEAT));

  // Beat capture and running ECC; the seed is forced to zero on beat 0 so a
  // back-to-back packet never inherits the previous packet's remainder.
  always_comb begin : capture_comb
    logic [ECC_W-1:0] seed;
    cnt_d     = '0;
    hdr_cap_d = hdr_cap_q;
    hdr_par_d = hdr_par_q;
    hdr_ecc_d = hdr_ecc_q;
    sub_cap_d = sub_cap_q;
    sub_par_d = sub_par_q;
    sub_ecc_d = sub_ecc_q;
    seed      = '0;
    if (data_island_period) begin
      cnt_d = cnt_q + CNT_W'(1);
      seed  = (cnt_q == '0) ? ECC_W'(0) : hdr_ecc_q;
      if (cnt_q < CNT_W'(HDR_BEATS)) begin
        hdr_cap_d[cnt_q] = packet_data[0];
        hdr_ecc_d        = ecc_step(seed, packet_data[0]);
      end else begin
        hdr_par_d[cnt_q[2:0]] = packet_data[0];
      end
      for (int i = 0; i < NUM_SUB; i++) begin
        seed = (cnt_q == '0) ? ECC_W'(0) : sub_ecc_q[i];
        if (cnt_q < CNT_W'(SUB_BEATS)) begin
          sub_cap_d[i][{cnt_q, 1'b0}] = packet_data[1+i];
          sub_cap_d[i][{cnt_q, 1'b1}] = packet_data[5+i];
          sub_ecc_d[i] = ecc_step(ecc_step(seed, packet_data[1+i]), packet_data[5+i]);
        end else begin
          sub_par_d[i][{cnt_q[1:0], 1'b0}] = packet_data[1+i];
          sub_par_d[i][{cnt_q[1:0], 1'b1}] = packet_data[5+i];
        end
      end
    end else begin
      hdr_cap_d = '0;
      hdr_par_d = '0;
      hdr_ecc_d = '0;
      sub_cap_d = '0;
      sub_par_d = '0;
      sub_ecc_d = '0;
    end
  end

  // Parity verdict, valid only on the last beat when every parity bit is in.
  always_comb begin : check_comb
    hdr_ok_c = (hdr_ecc_d == hdr_par_d);
    sub_ok_c = '0;
    for (int i = 0; i < NUM_SUB; i++) begin
      sub_ok_c[i] = (sub_ecc_d[i] == sub_par_d[i]);
    end
    pkt_err_c = !hdr_ok_c || (sub_ok_c != {NUM_SUB{1'b1}});
  end

  always_comb begin : deliver_comb
    header_d = header_q;
    sub_d    = sub_q;
    hdr_ok_d = hdr_ok_q;
    sub_ok_d = sub_ok_q;
    valid_d  = 1'b0;
    error_d  = 1'b0;
    if (last_beat_c) begin
      error_d = pkt_err_c;
      if (!DROP_BAD || !pkt_err_c) begin
        header_d = hdr_cap_d;
        sub_d    = sub_cap_d;
        hdr_ok_d = hdr_ok_c;
        sub_ok_d = sub_ok_c;
        valid_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      cnt_q     <= '0;
      hdr_cap_q <= '0;
      hdr_par_q <= '0;
      hdr_ecc_q <= '0;
      sub_cap_q <= '0;
      sub_par_q <= '0;
      sub_ecc_q <= '0;
      header_q  <= '0;
      sub_q     <= '0;
      hdr_ok_q  <= 1'b0;
      sub_ok_q  <= '0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      hdr_cap_q <= last_beat_c ? '0 : hdr_cap_d;
      hdr_par_q <= last_beat_c ? '0 : hdr_par_d;
      hdr_ecc_q <= last_beat_c ? '0 : hdr_ecc_d;
      sub_cap_q <= last_beat_c ? '0 : sub_cap_d;
      sub_par_q <= last_beat_c ? '0 : sub_par_d;
      sub_ecc_q <= last_beat_c ? '0 : sub_ecc_d;
      header_q  <= header_d;
      sub_q     <= sub_d;
      hdr_ok_q  <= hdr_ok_d;
      sub_ok_q  <= sub_ok_d;
      valid_q   <= valid_d;
      error_q   <= error_d;
    end
  end

  assign header        = header_q;
  assign sub           = sub_q;
  assign header_ecc_ok = hdr_ok_q;
  assign sub_ecc_ok    = sub_ok_q;
  assign packet_valid  = valid_q;
  assign packet_error  = error_q;
  assign counter       = cnt_q;

endmodule

// File: doc/packet_disassembler.md
Name: packet_disassembler

Overview:
- Receive-side counterpart of the HDMI data-island packet path. Consumes the 9-bit per-pixel packet stream recovered from TMDS channels 0–2 during data-island periods.
- Reassembles the 24-bit header and four 56-bit subpackets. Recomputes the BCH ECC for all five blocks and checks it against the received parity bytes.
- Presents each completed packet with a one-cycle valid strobe and per-block ECC status to downstream packet decoders (infoframe/ACR/audio parsers).

Parameters:
- DROP_BAD, 0, 1 = suppress packet_valid when any block fails ECC (packet_error still pulses); 0 = always deliver with status flags.

Ports:
- clk_pixel  in  1  pixel clock; single clock domain
- reset  in  1  synchronous, active-high reset
- data_island_period  in  1  high while packet_data carries island data
- packet_data  in  9  bit0 = header bit; bits1–4 = subpacket 0–3 even bit; bits5–8 = subpacket 0–3 odd bit
- header  out  24  last delivered header, bit 0 first received
- sub  out  4x56  last delivered subpackets 0–3
- header_ecc_ok  out  1  header parity matched
- sub_ecc_ok  out  4  per-subpacket parity matched
- packet_valid  out  1  one-cycle strobe: outputs updated
- packet_error  out  1  one-cycle strobe with any ECC mismatch
- counter  out  5  current beat index 0–31 within the packet

Behaviour:
- Reset values: all outputs 0; counter 0; shift/ECC state 0.
- Beat counter:
  - Increments on every clk_pixel with data_island_period high; wraps 31→0, so back-to-back packets need no gap.
  - Cleared to 0 on any cycle with data_island_period low.
- Beat k = counter value when the beat is sampled:
  - k 0–23: packet_data[0] is header bit k.
  - k 24–31: packet_data[0] is header parity bit k−24.
  - For subpacket i, k 0–27: packet_data[1+i] is data bit 2k and packet_data[5+i] is data bit 2k+1.
  - For subpacket i, k 28–31: the same two lanes carry parity bits 2(k−28) and 2(k−28)+1.
- ECC step: ecc' = (ecc>>1) XOR (ecc[0] XOR bit ? 8'h83 : 8'h00).
  - Start value 0 at k=0.
  - Header: one step per beat for k 0–23.
  - Subpackets: two chained steps per beat for k 0–27, even bit first.
  - Parity bytes are captured LSB first and excluded from the ECC.
- Completion: on the beat with k=31 (island high), the next cycle drives:
  - header, sub, and all ecc_ok flags from the just-completed packet;
  - packet_valid = 1;
  - packet_error = 1 if any ecc_ok is 0.
  - Latency is 1 cycle after the last beat.
  - With DROP_BAD=1 and an error: header/sub/ecc_ok are not updated, packet_valid stays 0, packet_error still pulses.
- Outputs hold their values between strobes.
- Abort: if data_island_period falls before k=31 completes, discard the partial packet: no strobe, ECC and capture state cleared, counter back to 0. A later island restarts at k=0.
- Completion and a new packet's k=0 beat in the same cycle (back-to-back) are independent. The new packet's ECC starts from 0 while the previous packet is being delivered; no beat is lost.
- Reset mid-packet: the partial packet is discarded and all outputs return to reset values on the next edge.
- No backpressure: the consumer must accept the strobe the cycle it occurs.

Test Plan:
- Null packet, all 32 beats packet_data=9'h000 → packet_valid exactly 1 cycle after beat 31; header=0; sub all 0; header_ecc_ok=1; sub_ecc_ok=4'hF; packet_error=0.
- Header 24'h000001 with header parity 8'h4A; subpackets zero with parity 0 → header=24'h000001, header_ecc_ok=1. Same packet with parity 8'h4B → header_ecc_ok=0, packet_error=1; with DROP_BAD=1, no packet_valid and outputs unchanged.
- Subpacket 2 = 56'hAA_5500_FF00_1234 serialized on lanes 3/7, correct parity from the bench golden BCH model → sub[2] exact match, sub_ecc_ok=4'hF. Flip a single data bit at k=13 → sub_ecc_ok=4'b1011.
- Three back-to-back packets over 96 continuous island cycles → three strobes spaced exactly 32 cycles apart, each with correct contents; counter wraps 31→0 each time.
- data_island_period dropped at k=17, then a full packet sent → only one strobe, carrying the second packet with all ECC ok.
- reset asserted at k=20 of a packet, then a full packet sent → all outputs 0 after reset; one strobe for the following packet with correct data.
